// File: rtl/backdoor_spi_pkg.sv
// Shared types and default widths for the backdoor bus controller.
package backdoor_spi_pkg;

    localparam int BD_REG_ADDR_W     = 4;
    localparam int BD_MOD_SEL_W      = 3;
    localparam int BD_ADDRESS_WIDTH  = 8;
    localparam int BD_DATA_WIDTH     = 32;
    localparam int BD_NUM_MODULES    = 8;
    localparam int BD_TIMEOUT_CYCLES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_RD_REQ,
        ST_WR_REQ,
        ST_DONE
    } bd_state_e;

endpackage

// File: rtl/backdoor_bus_timeout.sv
// Request watchdog: counts cycles without ack and flags expiry at LIMIT.
module backdoor_bus_timeout #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_W'(LIMIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/backdoor_bus_ctrl.sv
// Backdoor SPI to submodule bus sequencer: one read or write per SPI frame.
// Optional ack watchdog enabled by defining BACKDOOR_BUS_CTRL_TIMEOUT_EN.
module backdoor_bus_ctrl
    import backdoor_spi_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = BD_ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = BD_DATA_WIDTH,
    parameter int NUM_MODULES    = BD_NUM_MODULES,
    parameter int TIMEOUT_CYCLES = BD_TIMEOUT_CYCLES
) (
    input  logic                              i_SYSCLK,
    input  logic                              i_RST_N,
    input  logic                              i_ADDR_VALID,
    input  logic                              i_READ,
    input  logic [ADDRESS_WIDTH-2:0]          i_ADDR,
    input  logic [DATA_WIDTH-1:0]             i_DATA_IN,
    input  logic                              i_DOUT_VALID,
    input  logic [NUM_MODULES-1:0]            i_MOD_ACK,
    input  logic [NUM_MODULES*DATA_WIDTH-1:0] i_MOD_RDATA,
    output logic [NUM_MODULES-1:0]            o_MOD_SEL,
    output logic                              o_RD_EN,
    output logic                              o_WR_EN,
    output logic [BD_REG_ADDR_W-1:0]          o_REG_ADDR,
    output logic [DATA_WIDTH-1:0]             o_WDATA,
    output logic [DATA_WIDTH-1:0]             o_DATA_OUT,
    output logic                              o_BUSY,
    output logic                              o_ERR
);

    localparam int SEL_SPAN = 1 << BD_MOD_SEL_W;

    bd_state_e               state, next_state;
    logic                    valid_q;
    logic [BD_MOD_SEL_W-1:0] mod_idx;
    logic [SEL_SPAN-1:0]     ack_ext;
    logic                    ack_hit, timeout, capture, bad_mod, in_req;
    logic [DATA_WIDTH-1:0]   rdata_sel;

    assign in_req  = (state == ST_RD_REQ) || (state == ST_WR_REQ);
    assign capture = (state == ST_IDLE) && i_ADDR_VALID && !valid_q;
    assign bad_mod = int'(i_ADDR[BD_MOD_SEL_W-1:0]) >= NUM_MODULES;
    assign o_BUSY  = (state != ST_IDLE);

    // Widen the ack vector so the 3-bit index is always in range.
    always_comb begin
        ack_ext = '0;
        ack_ext[NUM_MODULES-1:0] = i_MOD_ACK;
        ack_hit = ack_ext[mod_idx];
        rdata_sel = '0;
        o_MOD_SEL = '0;
        for (int unsigned k = 0; k < NUM_MODULES; k++) begin
            if (mod_idx == BD_MOD_SEL_W'(k)) begin
                rdata_sel    = i_MOD_RDATA[k*DATA_WIDTH +: DATA_WIDTH];
                o_MOD_SEL[k] = o_RD_EN || o_WR_EN;
            end
        end
    end

`ifdef BACKDOOR_BUS_CTRL_TIMEOUT_EN
    backdoor_bus_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (i_SYSCLK),
        .rst_n  (i_RST_N),
        .clear  (!in_req),
        .enable (in_req && !ack_hit),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_SYSCLK) begin
        if (!i_RST_N) state <= ST_IDLE;
        else          state <= next_state;
    end

    // Ack outranks timeout and abort; abort only matters once nothing else fired.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (capture) begin
                    if (bad_mod)     next_state = ST_DONE;
                    else if (i_READ) next_state = ST_RD_REQ;
                    else             next_state = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (!i_ADDR_VALID)     next_state = ST_IDLE;
                else if (i_DOUT_VALID) next_state = ST_WR_REQ;
            end
            ST_RD_REQ, ST_WR_REQ: begin
                if (ack_hit || timeout) next_state = ST_DONE;
                else if (!i_ADDR_VALID) next_state = ST_IDLE;
            end
            ST_DONE: begin
                if (!i_ADDR_VALID) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_SYSCLK) begin
        if (!i_RST_N) begin
            valid_q    <= 1'b0;
            mod_idx    <= '0;
            o_REG_ADDR <= '0;
            o_RD_EN    <= 1'b0;
            o_WR_EN    <= 1'b0;
            o_WDATA    <= '0;
            o_DATA_OUT <= '0;
            o_ERR      <= 1'b0;
        end else begin
            valid_q <= i_ADDR_VALID;
            // Requests track "still in the request state next cycle", giving a one-cycle lag.
            o_RD_EN <= (state == ST_RD_REQ) && (next_state == ST_RD_REQ);
            o_WR_EN <= (state == ST_WR_REQ) && (next_state == ST_WR_REQ);
            if (capture) begin
                o_REG_ADDR <= i_ADDR[BD_MOD_SEL_W +: BD_REG_ADDR_W];
                mod_idx    <= i_ADDR[BD_MOD_SEL_W-1:0];
                o_ERR      <= bad_mod;
                if (bad_mod) o_DATA_OUT <= '0;
            end
            if ((state == ST_WAIT_DATA) && (next_state == ST_WR_REQ)) begin
                o_WDATA <= i_DATA_IN;
            end
            if ((state == ST_RD_REQ) && ack_hit) begin
                o_DATA_OUT <= rdata_sel;
            end else if (in_req && !ack_hit && timeout) begin
                o_ERR <= 1'b1;
                if (state == ST_RD_REQ) o_DATA_OUT <= '0;
            end
        end
    end

endmodule

// File: tb/tb_backdoor_bus_ctrl.sv
// Randomized and directed checks of backdoor_bus_ctrl against a transaction-level model.
module tb_backdoor_bus_ctrl;

    localparam int NM = 6;
    localparam int DW = 32;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            addr_valid;
    logic            read;
    logic [AW-2:0]   addr;
    logic [DW-1:0]   data_in;
    logic            dout_valid;
    logic [NM-1:0]   mod_ack;
    logic [NM*DW-1:0] mod_rdata;
    logic [NM-1:0]   mod_sel;
    logic            rd_en, wr_en, busy, err;
    logic [3:0]      reg_addr;
    logic [DW-1:0]   wdata, data_out;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_dout, m_wdata;
    logic        m_err;

    always #5 clk = ~clk;

    backdoor_bus_ctrl #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .NUM_MODULES   (NM),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_SYSCLK    (clk),
        .i_RST_N     (rst_n),
        .i_ADDR_VALID(addr_valid),
        .i_READ      (read),
        .i_ADDR      (addr),
        .i_DATA_IN   (data_in),
        .i_DOUT_VALID(dout_valid),
        .i_MOD_ACK   (mod_ack),
        .i_MOD_RDATA (mod_rdata),
        .o_MOD_SEL   (mod_sel),
        .o_RD_EN     (rd_en),
        .o_WR_EN     (wr_en),
        .o_REG_ADDR  (reg_addr),
        .o_WDATA     (wdata),
        .o_DATA_OUT  (data_out),
        .o_BUSY      (busy),
        .o_ERR       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NM-1:0] onehot(input int i);
        return NM'(1) << i;
    endfunction

    function automatic logic [NM-1:0] noise(input int i);
        return NM'($urandom) & ~onehot(i);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_req"}, 32'({rd_en, wr_en}), 32'(0));
        check({tag, "_sel"}, 32'(mod_sel), 32'(0));
        check({tag, "_dout"}, data_out, m_dout);
        check({tag, "_err"}, 32'(m_err), 32'(err));
    endtask

    // Drives the selected ack once the request has been high for lat cycles.
    task automatic req_phase(input bit is_rd, input int lat, input int idx,
                             input bit drop_at_ack, output int high);
        bit acked = 1'b0;
        int cyc = 0;
        high = 0;
        while (!acked && cyc < 200) begin
            @(negedge clk);
            cyc++;
            mod_ack = noise(idx);
            if ((is_rd ? rd_en : wr_en) === 1'b1) begin
                high++;
                check("req_sel", 32'(mod_sel), 32'(onehot(idx)));
                check("req_excl", 32'(is_rd ? wr_en : rd_en), 32'(0));
                if (high == lat) begin
                    mod_ack = noise(idx) | onehot(idx);
                    acked = 1'b1;
                    if (drop_at_ack) addr_valid = 1'b0;
                end
            end
        end
        check("ack_reached", 32'(acked), 32'(1));
        @(negedge clk);
        mod_ack = '0;
        check("req_drop", 32'({rd_en, wr_en}), 32'(0));
        check("done_busy", 32'(busy), 32'(1));
    endtask

    task automatic do_read(input logic [6:0] a, input int lat, input logic [31:0] d,
                           input bit drop_at_ack);
        int idx = int'(a[2:0]);
        int high;
        for (int k = 0; k < NM; k++) mod_rdata[k*DW +: DW] = $urandom;
        if (idx < NM) mod_rdata[idx*DW +: DW] = d;
        @(negedge clk);
        addr = a; read = 1'b1; addr_valid = 1'b1;
        if (idx >= NM) begin
            m_err = 1'b1; m_dout = '0;
            @(negedge clk);
            @(negedge clk);
            check("bad_err", 32'(err), 32'(m_err));
            check("bad_dout", data_out, m_dout);
            check("bad_req", 32'({rd_en, wr_en}), 32'(0));
            check("bad_busy", 32'(busy), 32'(1));
        end else begin
            req_phase(1'b1, lat, idx, drop_at_ack, high);
            m_dout = d; m_err = 1'b0;
            check("rd_len", 32'(high), 32'(lat));
            check("rd_dout", data_out, m_dout);
            check("rd_err", 32'(err), 32'(m_err));
            check("rd_reg", 32'(reg_addr), 32'(a[6:3]));
        end
        addr_valid = 1'b0;
        @(negedge clk);
        check_idle("rd_end");
    endtask

    task automatic do_write(input logic [6:0] a, input int lat, input logic [31:0] d,
                            input int pre_wait);
        int idx = int'(a[2:0]);
        int high;
        @(negedge clk);
        dout_valid = 1'b1; data_in = $urandom;
        @(negedge clk);
        dout_valid = 1'b0;
        check("stray_wdata", wdata, m_wdata);
        addr = a; read = 1'b0; addr_valid = 1'b1;
        if (idx >= NM) begin
            m_err = 1'b1; m_dout = '0;
            @(negedge clk);
            check("badw_err", 32'(err), 32'(m_err));
            check("badw_dout", data_out, m_dout);
            check("badw_req", 32'({rd_en, wr_en}), 32'(0));
        end else begin
            repeat (pre_wait) begin
                @(negedge clk);
                check("wait_busy", 32'({busy, wr_en}), 32'(2));
            end
            data_in = d; dout_valid = 1'b1;
            @(negedge clk);
            dout_valid = 1'b0;
            m_wdata = d;
            check("wr_wdata", wdata, m_wdata);
            req_phase(1'b0, lat, idx, 1'b0, high);
            m_err = 1'b0;
            check("wr_len", 32'(high), 32'(lat));
            check("wr_err", 32'(err), 32'(m_err));
            check("wr_dout", data_out, m_dout);
            check("wr_reg", 32'(reg_addr), 32'(a[6:3]));
        end
        addr_valid = 1'b0;
        @(negedge clk);
        check_idle("wr_end");
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; addr_valid = 1'b0; read = 1'b0; addr = '0; data_in = '0;
        dout_valid = 1'b0; mod_ack = '0; mod_rdata = '0;
        m_dout = '0; m_wdata = '0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_wdata", wdata, 32'(0));
        check("reset_reg", 32'(reg_addr), 32'(0));
        rst_n = 1'b1;

        do_read(7'h2A, 3, 32'hCAFE_0005, 1'b0);
        do_write(7'h08, 2, 32'h1234_5678, 2);
        do_read(7'h06, 1, 32'h0, 1'b0);
        do_read(7'h1B, 1, 32'hA5A5_0001, 1'b1);
        do_write(7'h7F, 1, 32'h0BAD_0BAD, 1);
        do_write(7'h45, 4, 32'h5555_AAAA, 1);

        // Abort in WAIT_DATA, then a late data pulse must be ignored.
        @(negedge clk);
        addr = 7'h11; read = 1'b0; addr_valid = 1'b1;
        repeat (2) @(negedge clk);
        addr_valid = 1'b0;
        @(negedge clk);
        check_idle("abort_wait");
        data_in = 32'hDEAD_BEEF; dout_valid = 1'b1;
        @(negedge clk);
        dout_valid = 1'b0;
        @(negedge clk);
        check("abort_wait_wdata", wdata, m_wdata);
        check_idle("abort_wait_late");

        // Abort in RD_REQ after two request cycles without ack.
        addr = 7'h5C; read = 1'b1; addr_valid = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 2; c++) begin
            @(negedge clk);
            if (rd_en === 1'b1) cnt++;
        end
        check("abort_rd_seen", 32'(cnt), 32'(2));
        addr_valid = 1'b0;
        @(negedge clk);
        check_idle("abort_rd");

        // Unanswered read: watchdog or indefinite hold depending on build.
        addr = 7'h23; read = 1'b1; addr_valid = 1'b1;
        @(negedge clk);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rd_en === 1'b1) cnt++;
        end
`ifdef BACKDOOR_BUS_CTRL_TIMEOUT_EN
        m_err = 1'b1; m_dout = '0;
        check("to_len", 32'(cnt), 32'(16));
        check("to_err", 32'(err), 32'(m_err));
        check("to_dout", data_out, m_dout);
`else
        check("hold_len", 32'(cnt), 32'(100));
`endif
        addr_valid = 1'b0;
        @(negedge clk);
        check_idle("hold_end");

        // Reset in the middle of a write request.
        addr = 7'h0C; read = 1'b0; addr_valid = 1'b1;
        @(negedge clk);
        data_in = 32'h7777_1111; dout_valid = 1'b1;
        @(negedge clk);
        dout_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10 && cnt == 0; c++) begin
            @(negedge clk);
            if (wr_en === 1'b1) cnt++;
        end
        check("rst_wr_seen", 32'(cnt), 32'(1));
        rst_n = 1'b0; addr_valid = 1'b0;
        @(negedge clk);
        m_dout = '0; m_err = 1'b0; m_wdata = '0;
        check_idle("mid_reset");
        check("mid_reset_wdata", wdata, m_wdata);
        check("mid_reset_reg", 32'(reg_addr), 32'(0));
        rst_n = 1'b1;
        do_read(7'h31, 2, 32'h0F0F_1234, 1'b0);

        for (int t = 0; t < 30; t++) begin
            logic [6:0] ra;
            ra = 7'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_read(ra, int'($urandom_range(1, 4)), $urandom, $urandom_range(0, 1) == 1);
            else
                do_write(ra, int'($urandom_range(1, 4)), $urandom, int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
